// File: rtl/drive_arbiter.sv
// ============================================================================
// drive_arbiter
// ----------------------------------------------------------------------------
// Chooses between the manual (Arduino link) and the automatic (decision tree)
// drive sources and produces one registered drive code for the motor stage.
// Direct forward<->backward reversals and source switches are separated by a
// forced-stop DEAD interval so the gearbox never sees an instant reversal.
// In manual mode a watchdog stops the vehicle if the link goes quiet.
// An obstacle stop (estop) overrides the drive output without disturbing
// the arbitration state underneath it.
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   man_cmd      in   8  manual byte: bit0 w, bit1 a, bit2 s, bit3 d (7:4 unused)
//   man_valid    in   1  one-cycle strobe qualifying man_cmd
//   manual_on    in   1  level, 1 selects the manual source
//   auto_cmd     in   4  drive code from the decision tree (9..15 mean Stop)
//   auto_valid   in   1  one-cycle strobe qualifying auto_cmd
//   estop        in   1  level obstacle stop, highest priority
//   drive_cmd    out  4  0 Stop,1 Fwd,2 Back,3 Left,4 Right,
//                        5 FwdLeft,6 FwdRight,7 BackLeft,8 BackRight
//   mode         out  2  0 none (IDLE or DEAD), 1 manual, 2 auto
//   dead_active  out  1  high while DEAD holds Stop
//   wdog_timeout out  1  high while the manual watchdog has expired
//
// DEAD_CYCLES must be at least 1.
// ============================================================================
module drive_arbiter #(
    parameter int WDOG_CYCLES = 50_000_000,
    parameter int DEAD_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] man_cmd,
    input  logic       man_valid,
    input  logic       manual_on,
    input  logic [3:0] auto_cmd,
    input  logic       auto_valid,
    input  logic       estop,
    output logic [3:0] drive_cmd,
    output logic [1:0] mode,
    output logic       dead_active,
    output logic       wdog_timeout
);

    // State codes double as mode / pend_mode codes for MANUAL and AUTO.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MANUAL = 2'd1;
    localparam logic [1:0] ST_AUTO   = 2'd2;
    localparam logic [1:0] ST_DEAD   = 2'd3;

    localparam logic [1:0] CLS_N = 2'd0;
    localparam logic [1:0] CLS_F = 2'd1;
    localparam logic [1:0] CLS_B = 2'd2;

    localparam int MAX_CYCLES = (WDOG_CYCLES > DEAD_CYCLES) ? WDOG_CYCLES : DEAD_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] WDOG_MAX  = CW'(WDOG_CYCLES);

    logic [1:0]    state_q,     state_d;
    logic [3:0]    cur_q,       cur_d;
    logic [3:0]    target_q,    target_d;
    logic [1:0]    pend_mode_q, pend_mode_d;
    logic [CW-1:0] dead_cnt_q,  dead_cnt_d;
    logic [CW-1:0] wdog_cnt_q,  wdog_cnt_d;
    logic          wdog_to_q,   wdog_to_d;
    logic          man_on_q,    man_on_d;
    logic [3:0]    drive_q,     drive_d;

    logic       src_change;
    logic       req_valid;
    logic [3:0] req_code;
    logic [1:0] src_mode;
    logic       accept;
    logic       reversal;
    logic       man_cmd_unused;

    assign man_cmd_unused = ^man_cmd[7:4];

    // w/a/s/d bit pattern to drive code; anything not listed is Stop.
    function automatic logic [3:0] decode_man(input logic [3:0] c);
        case (c)
            4'h1, 4'hA: decode_man = 4'd1;
            4'h4:       decode_man = 4'd2;
            4'h2:       decode_man = 4'd3;
            4'h8:       decode_man = 4'd4;
            4'h3:       decode_man = 4'd5;
            4'h9:       decode_man = 4'd6;
            4'h6:       decode_man = 4'd7;
            4'hC:       decode_man = 4'd8;
            default:    decode_man = 4'd0;
        endcase
    endfunction

    function automatic logic [1:0] dir_class(input logic [3:0] c);
        case (c)
            4'd1, 4'd5, 4'd6: dir_class = CLS_F;
            4'd2, 4'd7, 4'd8: dir_class = CLS_B;
            default:          dir_class = CLS_N;
        endcase
    endfunction

    // Request selection. A source switch outside IDLE always wins over a
    // strobe in the same cycle, so that strobe is dropped.
    always_comb begin
        src_change = (manual_on != man_on_q);
        req_valid  = manual_on ? man_valid : auto_valid;
        req_code   = manual_on ? decode_man(man_cmd[3:0])
                               : ((auto_cmd > 4'd8) ? 4'd0 : auto_cmd);
        src_mode   = manual_on ? ST_MANUAL : ST_AUTO;
        accept     = req_valid && !(src_change && (state_q != ST_IDLE));
        reversal   = ((dir_class(cur_q) == CLS_F) && (dir_class(req_code) == CLS_B)) ||
                     ((dir_class(cur_q) == CLS_B) && (dir_class(req_code) == CLS_F));
    end

    // Main arbitration. cur holds the drive code the state wants to show;
    // estop only masks it on the way to the output register, so releasing
    // estop brings the underlying value straight back.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        target_d    = target_q;
        pend_mode_d = pend_mode_q;
        dead_cnt_d  = dead_cnt_q;
        wdog_cnt_d  = '0;
        wdog_to_d   = 1'b0;
        man_on_d    = manual_on;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = src_mode;
                    cur_d       = req_code;
                    target_d    = req_code;
                    pend_mode_d = src_mode;
                end
            end

            ST_MANUAL, ST_AUTO: begin
                if (src_change) begin
                    state_d     = ST_DEAD;
                    cur_d       = 4'd0;
                    target_d    = 4'd0;
                    pend_mode_d = src_mode;
                    dead_cnt_d  = '0;
                end else if (accept) begin
                    target_d    = req_code;
                    pend_mode_d = src_mode;
                    if (reversal) begin
                        state_d    = ST_DEAD;
                        cur_d      = 4'd0;
                        dead_cnt_d = '0;
                    end else begin
                        cur_d = req_code;
                    end
                end else if (state_q == ST_MANUAL) begin
                    // Quiet manual link: count up and saturate; at the limit
                    // the vehicle stops but stays in MANUAL.
                    if (wdog_cnt_q != WDOG_MAX) begin
                        wdog_cnt_d = wdog_cnt_q + CW'(1);
                    end else begin
                        wdog_cnt_d = wdog_cnt_q;
                    end
                    if (wdog_cnt_d == WDOG_MAX) begin
                        wdog_to_d = 1'b1;
                        cur_d     = 4'd0;
                    end
                end
            end

            default: begin
                // DEAD: a source switch restarts the interval with a Stop
                // target; otherwise requests only refresh the target.
                if (src_change) begin
                    pend_mode_d = src_mode;
                    target_d    = 4'd0;
                    dead_cnt_d  = '0;
                end else begin
                    if (accept) begin
                        target_d    = req_code;
                        pend_mode_d = src_mode;
                    end
                    if (dead_cnt_q == DEAD_LAST) begin
                        state_d = pend_mode_d;
                        cur_d   = target_d;
                    end else begin
                        dead_cnt_d = dead_cnt_q + CW'(1);
                    end
                end
            end
        endcase

        drive_d = estop ? 4'd0 : cur_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_q       <= 4'd0;
            target_q    <= 4'd0;
            pend_mode_q <= ST_IDLE;
            dead_cnt_q  <= '0;
            wdog_cnt_q  <= '0;
            wdog_to_q   <= 1'b0;
            man_on_q    <= 1'b0;
            drive_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            target_q    <= target_d;
            pend_mode_q <= pend_mode_d;
            dead_cnt_q  <= dead_cnt_d;
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_to_q   <= wdog_to_d;
            man_on_q    <= man_on_d;
            drive_q     <= drive_d;
        end
    end

    assign drive_cmd    = drive_q;
    assign mode         = (state_q == ST_MANUAL) ? 2'd1 :
                          (state_q == ST_AUTO)   ? 2'd2 : 2'd0;
    assign dead_active  = (state_q == ST_DEAD);
    assign wdog_timeout = wdog_to_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// ============================================================================
// tb_drive_arbiter
// ----------------------------------------------------------------------------
// Directed walk through the main scenarios followed by a randomized phase.
// A behavioural model follows the arbitration rules cycle by cycle using
// plain integer bookkeeping (remaining dead time, quiet-cycle count) and
// every cycle the DUT outputs are compared against it.
// ============================================================================
module tb_drive_arbiter;

    localparam int D = 4;
    localparam int W = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] man_cmd = '0;
    logic       man_valid = 1'b0;
    logic       manual_on = 1'b0;
    logic [3:0] auto_cmd = '0;
    logic       auto_valid = 1'b0;
    logic       estop = 1'b0;
    logic [3:0] drive_cmd;
    logic [1:0] mode;
    logic       dead_active;
    logic       wdog_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: m_state 0 idle, 1 manual, 2 auto, 3 dead.
    int m_state, m_norm, m_target, m_pend, m_dead_left, m_quiet;
    bit m_timeout, m_prev_on, m_estop;

    int man_map [16] = '{0, 1, 3, 5, 2, 0, 7, 0, 4, 6, 1, 0, 8, 0, 0, 0};
    logic [7:0] legal_man [9] = '{8'h01, 8'h0A, 8'h04, 8'h02, 8'h08,
                                  8'h03, 8'h09, 8'h06, 8'h0C};

    drive_arbiter #(.WDOG_CYCLES(W), .DEAD_CYCLES(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .man_cmd     (man_cmd),
        .man_valid   (man_valid),
        .manual_on   (manual_on),
        .auto_cmd    (auto_cmd),
        .auto_valid  (auto_valid),
        .estop       (estop),
        .drive_cmd   (drive_cmd),
        .mode        (mode),
        .dead_active (dead_active),
        .wdog_timeout(wdog_timeout)
    );

    always #5 clk = ~clk;

    function automatic int dir_of(input int c);
        if (c inside {1, 5, 6}) return 1;
        if (c inside {2, 7, 8}) return 2;
        return 0;
    endfunction

    task automatic modelReset();
        m_state = 0; m_norm = 0; m_target = 0; m_pend = 0;
        m_dead_left = 0; m_quiet = 0; m_timeout = 0; m_prev_on = 0; m_estop = 0;
    endtask

    // One rising edge of the reference behaviour, using the sampled inputs.
    task automatic modelStep();
        bit changed;
        bit reqv;
        int code;
        int src;
        changed   = (manual_on != m_prev_on);
        m_prev_on = manual_on;
        m_estop   = estop;
        reqv = manual_on ? man_valid : auto_valid;
        code = manual_on ? man_map[man_cmd[3:0]] : ((int'(auto_cmd) > 8) ? 0 : int'(auto_cmd));
        src  = manual_on ? 1 : 2;
        case (m_state)
            0: if (reqv) begin
                m_state = src; m_norm = code; m_target = code; m_pend = src;
            end
            1, 2: begin
                if (changed) begin
                    m_state = 3; m_norm = 0; m_target = 0; m_pend = src;
                    m_dead_left = D; m_timeout = 0; m_quiet = 0;
                end else if (reqv) begin
                    m_target = code; m_pend = src; m_timeout = 0; m_quiet = 0;
                    if (dir_of(m_norm) + dir_of(code) == 3) begin
                        m_state = 3; m_norm = 0; m_dead_left = D;
                    end else begin
                        m_norm = code;
                    end
                end else if (m_state == 1) begin
                    if (m_quiet < W) m_quiet++;
                    if (m_quiet == W) begin
                        m_timeout = 1; m_norm = 0;
                    end
                end
            end
            default: begin
                if (changed) begin
                    m_pend = src; m_target = 0; m_dead_left = D;
                end else begin
                    if (reqv) begin
                        m_target = code; m_pend = src;
                    end
                    m_dead_left--;
                    if (m_dead_left == 0) begin
                        m_state = m_pend; m_norm = m_target;
                    end
                end
            end
        endcase
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".drive_cmd"},    32'(drive_cmd),    32'(m_estop ? 0 : m_norm));
        checkValue({tag, ".mode"},         32'(mode),         32'((m_state == 1 || m_state == 2) ? m_state : 0));
        checkValue({tag, ".dead_active"},  32'(dead_active),  32'(m_state == 3));
        checkValue({tag, ".wdog_timeout"}, 32'(wdog_timeout), 32'(m_timeout));
    endtask

    task automatic applyStimulus(input logic mon, input logic mv, input logic [7:0] mc,
                                 input logic av, input logic [3:0] ac, input logic es);
        manual_on  = mon;
        man_valid  = mv;
        man_cmd    = mc;
        auto_valid = av;
        auto_cmd   = ac;
        estop      = es;
    endtask

    task automatic stepCycle(input string tag);
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    // Asynchronous reset in mid-cycle: outputs must clear without a clock.
    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        checkValue({tag, ".drive_cmd"},    32'(drive_cmd),    32'd0);
        checkValue({tag, ".mode"},         32'(mode),         32'd0);
        checkValue({tag, ".dead_active"},  32'(dead_active),  32'd0);
        checkValue({tag, ".wdog_timeout"}, 32'(wdog_timeout), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        bit dense;
        $display("[TB] drive_arbiter test start");
        modelReset();
        applyStimulus(0, 0, 8'h00, 0, 4'd0, 0);
        #2;
        doReset("reset");

        // Manual forward from IDLE.
        applyStimulus(1, 0, 8'h00, 0, 4'd0, 0);
        stepCycle("idle");
        applyStimulus(1, 1, 8'h01, 0, 4'd0, 0);
        stepCycle("fwd");
        checkValue("fwd.drive", 32'(drive_cmd), 32'd1);
        checkValue("fwd.mode",  32'(mode),      32'd1);

        // Fwd -> Back reversal through DEAD.
        applyStimulus(1, 1, 8'h04, 0, 4'd0, 0);
        stepCycle("rev");
        checkValue("rev.dead0", 32'(dead_active), 32'd1);
        applyStimulus(1, 0, 8'h00, 0, 4'd0, 0);
        for (int i = 0; i < D - 1; i++) begin
            stepCycle("rev.hold");
            checkValue("rev.dead", 32'(dead_active), 32'd1);
        end
        stepCycle("rev.out");
        checkValue("rev.back", 32'(drive_cmd), 32'd2);

        // Non-reversing changes go straight through.
        applyStimulus(1, 1, 8'h02, 0, 4'd0, 0);
        stepCycle("left");
        applyStimulus(1, 1, 8'h01, 0, 4'd0, 0);
        stepCycle("fwd2");
        applyStimulus(1, 1, 8'h02, 0, 4'd0, 0);
        stepCycle("fwd_left");
        checkValue("fwd_left.drive", 32'(drive_cmd),   32'd3);
        checkValue("fwd_left.dead",  32'(dead_active), 32'd0);

        // Watchdog expiry and recovery.
        applyStimulus(1, 0, 8'h00, 0, 4'd0, 0);
        for (int i = 0; i < W - 1; i++) stepCycle("wdog.quiet");
        checkValue("wdog.before", 32'(wdog_timeout), 32'd0);
        stepCycle("wdog.expire");
        checkValue("wdog.drive", 32'(drive_cmd),    32'd0);
        checkValue("wdog.flag",  32'(wdog_timeout), 32'd1);
        for (int i = 0; i < 3; i++) stepCycle("wdog.sat");
        applyStimulus(1, 1, 8'h09, 0, 4'd0, 0);
        stepCycle("wdog.recover");
        checkValue("wdog.recover.drive", 32'(drive_cmd),    32'd6);
        checkValue("wdog.recover.flag",  32'(wdog_timeout), 32'd0);

        // Switch to auto, drive FwdLeft, then switch back with a dropped strobe.
        applyStimulus(0, 0, 8'h00, 0, 4'd0, 0);
        for (int i = 0; i < D + 1; i++) stepCycle("to_auto");
        checkValue("to_auto.mode", 32'(mode), 32'd2);
        applyStimulus(0, 0, 8'h00, 1, 4'd5, 0);
        stepCycle("auto5");
        checkValue("auto5.drive", 32'(drive_cmd), 32'd5);
        applyStimulus(1, 1, 8'h01, 0, 4'd0, 0);
        stepCycle("to_man");
        checkValue("to_man.dead", 32'(dead_active), 32'd1);
        applyStimulus(1, 0, 8'h00, 0, 4'd0, 0);
        for (int i = 0; i < D; i++) stepCycle("to_man.hold");
        checkValue("to_man.mode",  32'(mode),      32'd1);
        checkValue("to_man.drive", 32'(drive_cmd), 32'd0);
        applyStimulus(1, 1, 8'h0C, 0, 4'd0, 0);
        stepCycle("back_right");
        checkValue("back_right.drive", 32'(drive_cmd), 32'd8);

        // estop pulse while driving forward.
        applyStimulus(1, 1, 8'h02, 0, 4'd0, 0);
        stepCycle("pre_estop.left");
        applyStimulus(1, 1, 8'h01, 0, 4'd0, 0);
        stepCycle("pre_estop.fwd");
        applyStimulus(1, 0, 8'h00, 0, 4'd0, 1);
        for (int i = 0; i < 3; i++) begin
            stepCycle("estop");
            checkValue("estop.drive", 32'(drive_cmd), 32'd0);
        end
        applyStimulus(1, 0, 8'h00, 0, 4'd0, 0);
        stepCycle("estop.release");
        checkValue("estop.release.drive", 32'(drive_cmd), 32'd1);

        // Reset in the middle of DEAD.
        applyStimulus(1, 1, 8'h04, 0, 4'd0, 0);
        stepCycle("pre_rst.rev");
        applyStimulus(1, 0, 8'h00, 0, 4'd0, 0);
        stepCycle("pre_rst.dead");
        doReset("mid_dead_reset");

        // Randomized phase.
        dense = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [7:0] mc;
            if (cyc % 100 == 0) dense = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 599) == 0) begin
                doReset("rand.reset");
            end else begin
                mc = ($urandom_range(0, 1) == 1) ? legal_man[$urandom_range(0, 8)] : 8'($urandom);
                applyStimulus(($urandom_range(0, 39) == 0) ? ~manual_on : manual_on,
                              dense ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0),
                              mc,
                              dense ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0),
                              4'($urandom),
                              ($urandom_range(0, 29) == 0) || (estop && ($urandom_range(0, 2) != 0)));
                stepCycle("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/drive_arbiter.md
DRIVE_ARBITER -- requirements
Module: drive_arbiter

Interface
REQ-001 Parameter WDOG_CYCLES, default 50_000_000, manual-command watchdog period in clk cycles (1 s at 50 MHz).
REQ-002 Parameter DEAD_CYCLES, default 5_000_000, forced-stop interval on direction reversal or mode change.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 man_cmd  input  8  manual command byte from the Arduino link: bit0 = w, bit1 = a, bit2 = s, bit3 = d, bits 7:4 ignored.
REQ-006 man_valid  input  1  single-cycle strobe; man_cmd is valid in that cycle.
REQ-007 manual_on  input  1  level; 1 = manual source selected.
REQ-008 auto_cmd  input  4  drive code from the decision tree, encoded as in REQ-010.
REQ-009 auto_valid  input  1  single-cycle strobe; auto_cmd is valid in that cycle.
REQ-010 drive_cmd  output  4  registered drive code: 0 Stop, 1 Fwd, 2 Back, 3 Left, 4 Right, 5 FwdLeft, 6 FwdRight, 7 BackLeft, 8 BackRight.
REQ-011 mode  output  2  0 = none, 1 = manual, 2 = auto.
REQ-012 dead_active  output  1  high while the DEAD state holds Stop.
REQ-013 wdog_timeout  output  1  high while the manual watchdog has expired.
REQ-014 estop  input  1  level obstacle stop; highest priority.

Function
REQ-015 Decode of man_cmd[3:0]: 0x1 and 0xA -> Fwd; 0x4 -> Back; 0x2 -> Left; 0x8 -> Right; 0x3 -> FwdLeft; 0x9 -> FwdRight; 0x6 -> BackLeft; 0xC -> BackRight; every other value, including 0x0 and 0x5, -> Stop.
REQ-016 auto_cmd values 9-15 are treated as Stop.
REQ-017 Direction classes: F = {1, 5, 6}; B = {2, 7, 8}; N = {0, 3, 4}.
REQ-018 States: IDLE, MANUAL, AUTO, DEAD.
REQ-019 Active source: manual when manual_on = 1, auto otherwise. A request is accepted only on the active source's valid strobe.
REQ-020 Register target holds the last accepted decoded code. pend_mode holds the mode of the source that produced target.
REQ-021 IDLE: drive_cmd = 0, mode = 0. The first accepted request goes directly to MANUAL or AUTO, and drive_cmd = target takes effect the cycle after the strobe.
REQ-022 MANUAL/AUTO: an accepted request updates drive_cmd one cycle after the strobe, unless the current and new classes are F and B (in either order).
REQ-023 On an F<->B reversal: go to DEAD, drive_cmd = 0 the cycle after the strobe, and the new code is stored in target.
REQ-024 A change of manual_on while in MANUAL or AUTO: go to DEAD, drive_cmd = 0, target = 0, pend_mode = new source.
REQ-025 DEAD: drive_cmd = 0 and dead_active = 1 for exactly DEAD_CYCLES cycles. Accepted requests during DEAD overwrite target without restarting the count.
REQ-026 DEAD expiry: next cycle, go to the state of pend_mode with drive_cmd = target.
REQ-027 A manual_on change during DEAD updates pend_mode, sets target = 0, and restarts the count.
REQ-028 Watchdog, MANUAL only: the counter clears on each accepted man_valid and increments otherwise.
REQ-029 When the watchdog count reaches WDOG_CYCLES: drive_cmd = 0, wdog_timeout = 1, state remains MANUAL. The next accepted man_valid clears wdog_timeout and applies REQ-022.
REQ-030 The watchdog counter is held at 0 in AUTO, IDLE and DEAD. It saturates and does not wrap.
REQ-031 estop = 1: drive_cmd = 0 the next cycle; state, target and counters are unchanged. When estop deasserts, drive_cmd resumes the state's normal value on the next cycle.
REQ-032 Simultaneous man_valid and auto_valid: only the active-source strobe is used.
REQ-033 Simultaneous strobe and manual_on change in the same cycle: the mode change (REQ-024) wins and the strobe is discarded.
REQ-034 Counters are sized $clog2(max(WDOG_CYCLES, DEAD_CYCLES) + 1).

Reset
REQ-035 rst_n = 0 asynchronously forces: state IDLE, drive_cmd = 0, mode = 0, dead_active = 0, wdog_timeout = 0, target = 0, all counters = 0.
REQ-036 Reset asserted mid-DEAD or mid-watchdog aborts the operation. After release the block behaves as from power-up.

Verification (DEAD_CYCLES = 4, WDOG_CYCLES = 10)
REQ-037 manual_on = 1, man_valid with 0x01 -> next cycle drive_cmd = 1, mode = 1.
REQ-038 In Fwd, man_valid with 0x04 -> drive_cmd = 0 and dead_active = 1 for 4 cycles, then drive_cmd = 2.
REQ-039 In Fwd, man_valid with 0x02 -> next cycle drive_cmd = 3, no DEAD.
REQ-040 In MANUAL, no man_valid for 10 cycles -> drive_cmd = 0, wdog_timeout = 1; then man_valid 0x09 -> drive_cmd = 6, wdog_timeout = 0.
REQ-041 In AUTO with drive_cmd = 5, manual_on rises -> DEAD for 4 cycles, then mode = 1, drive_cmd = 0; man_valid 0x0C -> drive_cmd = 8.
REQ-042 estop pulse of 3 cycles while drive_cmd = 1 -> drive_cmd = 0 during the pulse and back to 1 after; rst_n low mid-DEAD -> all outputs 0 immediately.
